// File: rtl/atto_pkg.sv
// Shared types and constants for the atto two-master memory bus arbiter.
package atto_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

endpackage

// File: rtl/atto_bus_arb_if.sv
// Master request/grant handshakes plus the shared memory-side bus of the arbiter.
interface atto_bus_arb_if;
    import atto_pkg::*;

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] address_bus;
    logic              data_dir;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [DATA_W-1:0] data_in;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  data_in,
        output m0_gnt, m0_done, m1_gnt, m1_done,
        output rdata, address_bus, data_dir, data_out, data_oe
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output data_in,
        input  m0_gnt, m0_done, m1_gnt, m1_done,
        input  rdata, address_bus, data_dir, data_out, data_oe
    );

endinterface

// File: rtl/atto_rr_pick.sv
// Two-way round-robin winner select; the master not granted last wins a tie.
module atto_rr_pick (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       winner_c,
    output logic       valid_c
);

    always_comb begin
        valid_c  = |req;
        winner_c = 1'b0;
        if (req == 2'b11) winner_c = ~last_gnt;
        else              winner_c = req[1];
    end

endmodule

// File: rtl/atto_bus_arb.sv
// Round-robin arbiter owning a single memory transfer at a time: IDLE -> ADDR -> WAIT* -> DONE.
module atto_bus_arb
    import atto_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input logic          clock,
    input logic          reset,
    atto_bus_arb_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              oe_q, oe_d;
    logic              dir_q, dir_d;

    logic  winner;
    logic  valid;
    logic  last_cycle;
    xfer_t sel;

    atto_rr_pick u_pick (
        .req      ({bus.m1_req, bus.m0_req}),
        .last_gnt (last_q),
        .winner_c (winner),
        .valid_c  (valid)
    );

    // Next-state and next-output logic; every output is the registered image of these.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        oe_d    = oe_q;
        dir_d   = dir_q;

        sel.we    = winner ? bus.m1_we    : bus.m0_we;
        sel.addr  = winner ? bus.m1_addr  : bus.m0_addr;
        sel.wdata = winner ? bus.m1_wdata : bus.m0_wdata;

        last_cycle = ((state_q == ST_ADDR) && (MEM_WAIT == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd0));

        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_ADDR;
                    owner_d = winner;
                    last_d  = winner;
                    we_d    = sel.we;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    addr_d  = sel.addr;
                    dout_d  = sel.wdata;
                    oe_d    = sel.we;
                    dir_d   = ~sel.we;
                end
            end
            ST_ADDR: begin
                if (MEM_WAIT != 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: state_d = ST_IDLE;
        endcase

        // Leaving the final access cycle: complete the transfer and release the data bus.
        if (last_cycle) begin
            state_d         = ST_DONE;
            done_d[owner_q] = 1'b1;
            oe_d            = 1'b0;
            dir_d           = 1'b1;
            if (!we_q) rdata_d = bus.data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= M1;
            owner_q <= M0;
            we_q    <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            oe_q    <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.m0_gnt      = gnt_q[0];
    assign bus.m1_gnt      = gnt_q[1];
    assign bus.m0_done     = done_q[0];
    assign bus.m1_done     = done_q[1];
    assign bus.rdata       = rdata_q;
    assign bus.address_bus = addr_q;
    assign bus.data_dir    = dir_q;
    assign bus.data_out    = dout_q;
    assign bus.data_oe     = oe_q;

endmodule

// File: tb/tb_atto_bus_arb.sv
// Directed bench for atto_bus_arb at MEM_WAIT = 0, 1 and 3.
module tb_atto_bus_arb;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    atto_bus_arb_if bus0 ();
    atto_bus_arb_if bus1 ();
    atto_bus_arb_if bus3 ();

    atto_bus_arb #(.MEM_WAIT(0)) u_w0 (.clock(clock), .reset(reset), .bus(bus0));
    atto_bus_arb #(.MEM_WAIT(1)) u_w1 (.clock(clock), .reset(reset), .bus(bus1));
    atto_bus_arb #(.MEM_WAIT(3)) u_w3 (.clock(clock), .reset(reset), .bus(bus3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({bus1.m1_gnt, bus1.m0_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", {bus1.m1_gnt, bus1.m0_gnt}); end
        checks++; if ({bus1.m1_done, bus1.m0_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", {bus1.m1_done, bus1.m0_done}); end
        checks++; if (bus1.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus1.rdata); end
        checks++; if (bus1.address_bus !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", bus1.address_bus); end
        checks++; if ({bus1.data_dir, bus1.data_oe, bus1.data_out} !== {1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL reset_bus got dir=%b oe=%b out=%h want dir=1 oe=0 out=00", bus1.data_dir, bus1.data_oe, bus1.data_out); end
    endtask

    task automatic test_read_w1();
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 16'h1234;
        bus1.data_in = 8'hA5;
        tick();
        checks++; if ({bus1.m1_gnt, bus1.m0_gnt, bus1.m0_done} !== 3'b010) begin errors++; $display("FAIL read_addr_gnt got gnt=%b%b done=%b want gnt=01 done=0", bus1.m1_gnt, bus1.m0_gnt, bus1.m0_done); end
        checks++; if ({bus1.address_bus, bus1.data_dir, bus1.data_oe} !== {16'h1234, 1'b1, 1'b0}) begin errors++; $display("FAIL read_addr_bus got addr=%h dir=%b oe=%b want 1234 1 0", bus1.address_bus, bus1.data_dir, bus1.data_oe); end
        tick();
        checks++; if ({bus1.m0_done, bus1.address_bus} !== {1'b0, 16'h1234}) begin errors++; $display("FAIL read_wait got done=%b addr=%h want 0 1234", bus1.m0_done, bus1.address_bus); end
        tick();
        checks++; if ({bus1.m0_done, bus1.m1_done, bus1.m0_gnt} !== 3'b101) begin errors++; $display("FAIL read_done got done0=%b done1=%b gnt0=%b want 1 0 1", bus1.m0_done, bus1.m1_done, bus1.m0_gnt); end
        checks++; if (bus1.rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata got %h want a5", bus1.rdata); end
        bus1.m0_req = 1'b0;
        bus1.data_in = 8'h00;
        tick();
        checks++; if ({bus1.m0_gnt, bus1.m0_done, bus1.address_bus, bus1.rdata} !== {2'b00, 16'h1234, 8'hA5}) begin errors++; $display("FAIL read_idle got gnt=%b done=%b addr=%h rdata=%h want 0 0 1234 a5", bus1.m0_gnt, bus1.m0_done, bus1.address_bus, bus1.rdata); end
    endtask

    task automatic test_write_w0();
        bus0.m1_req = 1'b1; bus0.m1_we = 1'b1; bus0.m1_addr = 16'h8000; bus0.m1_wdata = 8'h3C;
        bus0.data_in = 8'hEE;
        tick();
        checks++; if ({bus0.m1_gnt, bus0.m0_gnt, bus0.m1_done} !== 3'b100) begin errors++; $display("FAIL write_gnt got gnt1=%b gnt0=%b done1=%b want 1 0 0", bus0.m1_gnt, bus0.m0_gnt, bus0.m1_done); end
        checks++; if ({bus0.address_bus, bus0.data_dir, bus0.data_oe, bus0.data_out} !== {16'h8000, 1'b0, 1'b1, 8'h3C}) begin errors++; $display("FAIL write_addr got addr=%h dir=%b oe=%b out=%h want 8000 0 1 3c", bus0.address_bus, bus0.data_dir, bus0.data_oe, bus0.data_out); end
        tick();
        checks++; if ({bus0.m1_done, bus0.data_oe, bus0.data_dir} !== 3'b101) begin errors++; $display("FAIL write_done got done=%b oe=%b dir=%b want 1 0 1", bus0.m1_done, bus0.data_oe, bus0.data_dir); end
        checks++; if (bus0.rdata !== 8'h00) begin errors++; $display("FAIL write_rdata got %h want 00", bus0.rdata); end
        bus0.m1_req = 1'b0;
        tick();
        checks++; if ({bus0.m1_gnt, bus0.m1_done, bus0.address_bus} !== {2'b00, 16'h8000}) begin errors++; $display("FAIL write_idle got gnt=%b done=%b addr=%h want 0 0 8000", bus0.m1_gnt, bus0.m1_done, bus0.address_bus); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic [1:0] exp_done;
        int ph;
        int own;
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 16'h0100;
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 16'h0200;
        bus1.data_in = 8'h11;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            tick();
            ph  = (k - 1) % 4;
            own = ((k - 1) / 4) % 2;
            exp_gnt  = (ph < 3) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_done = (ph == 2) ? exp_gnt : 2'b00;
            checks++; if ({bus1.m1_gnt, bus1.m0_gnt} !== exp_gnt) begin errors++; $display("FAIL contend_gnt cycle %0d got %b want %b", k, {bus1.m1_gnt, bus1.m0_gnt}, exp_gnt); end
            checks++; if ({bus1.m1_done, bus1.m0_done} !== exp_done) begin errors++; $display("FAIL contend_done cycle %0d got %b want %b", k, {bus1.m1_done, bus1.m0_done}, exp_done); end
            if (ph == 0) begin
                checks++; if (bus1.address_bus !== ((own == 1) ? 16'h0200 : 16'h0100)) begin errors++; $display("FAIL contend_addr cycle %0d got %h", k, bus1.address_bus); end
            end
        end
        bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_wait();
        bus3.m0_req = 1'b1; bus3.m0_we = 1'b0; bus3.m0_addr = 16'hBEEF;
        bus3.data_in = 8'h5A;
        tick();
        checks++; if (bus3.m0_gnt !== 1'b1) begin errors++; $display("FAIL rstwait_gnt got %b want 1", bus3.m0_gnt); end
        tick();
        tick();
        checks++; if ({bus3.m0_done, bus3.m0_gnt, bus3.address_bus} !== {2'b01, 16'hBEEF}) begin errors++; $display("FAIL rstwait_wait2 got done=%b gnt=%b addr=%h want 0 1 beef", bus3.m0_done, bus3.m0_gnt, bus3.address_bus); end
        reset = 1'b1;
        bus3.m1_req = 1'b1; bus3.m1_we = 1'b0; bus3.m1_addr = 16'h0042;
        tick();
        checks++; if ({bus3.m1_gnt, bus3.m0_gnt, bus3.m1_done, bus3.m0_done} !== 4'b0000) begin errors++; $display("FAIL rstwait_hs got %b%b%b%b want 0000", bus3.m1_gnt, bus3.m0_gnt, bus3.m1_done, bus3.m0_done); end
        checks++; if ({bus3.address_bus, bus3.rdata, bus3.data_out, bus3.data_dir, bus3.data_oe} !== {16'h0000, 8'h00, 8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL rstwait_bus got addr=%h rdata=%h out=%h dir=%b oe=%b", bus3.address_bus, bus3.rdata, bus3.data_out, bus3.data_dir, bus3.data_oe); end
        reset = 1'b0;
        tick();
        checks++; if ({bus3.m1_gnt, bus3.m0_gnt, bus3.address_bus} !== {2'b01, 16'hBEEF}) begin errors++; $display("FAIL rstwait_regrant got gnt=%b%b addr=%h want 01 beef", bus3.m1_gnt, bus3.m0_gnt, bus3.address_bus); end
        bus3.m0_req = 1'b0; bus3.m1_req = 1'b0;
        do_reset();
    endtask

    task automatic test_early_drop();
        int pulses;
        pulses = 0;
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b1; bus1.m1_addr = 16'h4242; bus1.m1_wdata = 8'h77;
        tick();
        checks++; if (bus1.m1_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt got %b want 1", bus1.m1_gnt); end
        bus1.m1_req = 1'b0;
        tick();
        checks++; if ({bus1.data_oe, bus1.data_out, bus1.m1_gnt} !== {1'b1, 8'h77, 1'b1}) begin errors++; $display("FAIL drop_wait got oe=%b out=%h gnt=%b want 1 77 1", bus1.data_oe, bus1.data_out, bus1.m1_gnt); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus1.m1_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulses got %0d want 1", pulses); end
        checks++; if ({bus1.m1_gnt, bus1.m0_gnt} !== 2'b00) begin errors++; $display("FAIL drop_idle_gnt got %b want 00", {bus1.m1_gnt, bus1.m0_gnt}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'h3A; vals[1] = 8'hC5; vals[2] = 8'h0F;
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 16'h7777;
        for (int t = 0; t < 3; t++) begin
            bus1.data_in = vals[t];
            for (int c = 1; c <= 4; c++) begin
                if (t == 2 && c == 4) bus1.m0_req = 1'b0;
                tick();
                checks++; if (bus1.m0_done !== ((c == 3) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL b2b_done xfer %0d cycle %0d got %b", t, c, bus1.m0_done); end
                if (c >= 3) begin
                    checks++; if (bus1.rdata !== vals[t]) begin errors++; $display("FAIL b2b_rdata xfer %0d cycle %0d got %h want %h", t, c, bus1.rdata, vals[t]); end
                end
            end
        end
        tick();
        checks++; if (bus1.m0_gnt !== 1'b0) begin errors++; $display("FAIL b2b_end_gnt got %b want 0", bus1.m0_gnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus0.m0_req = 1'b0; bus0.m0_we = 1'b0; bus0.m0_addr = '0; bus0.m0_wdata = '0;
        bus0.m1_req = 1'b0; bus0.m1_we = 1'b0; bus0.m1_addr = '0; bus0.m1_wdata = '0; bus0.data_in = '0;
        bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
        bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_addr = '0; bus1.m1_wdata = '0; bus1.data_in = '0;
        bus3.m0_req = 1'b0; bus3.m0_we = 1'b0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
        bus3.m1_req = 1'b0; bus3.m1_we = 1'b0; bus3.m1_addr = '0; bus3.m1_wdata = '0; bus3.data_in = '0;

        test_reset();
        test_read_w1();
        test_write_w0();
        test_contention();
        test_reset_mid_wait();
        test_early_drop();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
